// File: rtl/fsrcnn_pkg.sv
// Shared constants and types for the FSRCNN accelerator datapath.
//
// Contents:
//   TM          output channels carried per beat
//   ACC_W       signed accumulator / partial-sum width
//   DATA_W      signed output activation width
//   ALPHA_W     PReLU slope width (signed Q0.15)
//   ALPHA_FRAC  fractional bits of the PReLU slope
//   SHIFT_W     width of the output rescale shift amount
//   PSUM_ADDR_W default partial-sum buffer address width
//   fsm_state_t partial-sum accumulator control states
package fsrcnn_pkg;

    localparam int TM          = 4;
    localparam int ACC_W       = 32;
    localparam int DATA_W      = 16;
    localparam int ALPHA_W     = 16;
    localparam int ALPHA_FRAC  = 15;
    localparam int SHIFT_W     = 5;
    localparam int PSUM_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/prelu_quant.sv
// Single-channel output activation: PReLU, arithmetic rescale, saturation.
// Purely combinational; the caller registers the result.
//
// Ports:
//   v_in   in  ACC_W    signed accumulated value (bias already added)
//   alpha  in  ALPHA_W  signed Q0.15 slope applied to negative inputs
//   shift  in  SHIFT_W  arithmetic right shift applied after PReLU
//   q_out  out DATA_W   signed, saturated activation
module prelu_quant
    import fsrcnn_pkg::*;
(
    input  logic signed [ACC_W-1:0]   v_in,
    input  logic signed [ALPHA_W-1:0] alpha,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [DATA_W-1:0]  q_out
);

    localparam int PROD_W = ACC_W + ALPHA_W;

    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (DATA_W - 1)) - 1);
    // Two's complement: ~(2^(N-1)-1) == -2^(N-1).
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [PROD_W-1:0] v_ext;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] p_val;
    logic signed [PROD_W-1:0] q_val;

    always_comb begin
        v_ext = {{ALPHA_W{v_in[ACC_W-1]}}, v_in};
        a_ext = {{ACC_W{alpha[ALPHA_W-1]}}, alpha};
        // Full-width product cannot overflow: |v| <= 2^31, |alpha| <= 2^15.
        prod  = v_ext * a_ext;

        // Arithmetic shifts round toward minus infinity (floor).
        if (v_in[ACC_W-1]) begin
            p_val = prod >>> ALPHA_FRAC;
        end else begin
            p_val = v_ext;
        end

        q_val = p_val >>> shift;

        if (q_val > SAT_MAX) begin
            q_out = SAT_MAX[DATA_W-1:0];
        end else if (q_val < SAT_MIN) begin
            q_out = SAT_MIN[DATA_W-1:0];
        end else begin
            q_out = q_val[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator behind the multiply/adder-tree stage.
// Accumulates TM per-channel partial sums per output pixel across input
// tiles and kernel taps in an on-chip buffer; on a pixel's final pass it
// adds bias, applies PReLU, rescales, saturates and emits the pixel.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   cfg_load     latch bias_in / alpha_in / frac_shift (IDLE only)
//   bias_in      TM x ACC_W signed per-channel bias
//   alpha_in     TM x 16 signed Q0.15 per-channel PReLU slope
//   frac_shift   arithmetic right shift before saturation
//   psum_valid   partial-sum beat valid (no backpressure)
//   psum_in      TM x ACC_W signed partial sums, channel k at [k*ACC_W +: ACC_W]
//   psum_addr    output-pixel buffer address
//   psum_first   first pass: ignore buffer contents
//   psum_last    final pass: emit instead of writing back
//   tile_end     last beat of the tile
//   out_valid    one-cycle pulse per emitted pixel
//   out_data     TM x DATA_W saturated activations
//   out_addr     address of the emitted pixel
//   busy         controller not in IDLE
//   tile_done    one-cycle pulse once the tile has fully drained
//   drop_err     sticky: a beat arrived during DRAIN and was discarded
//
// Handshake: a beat is consumed on every rising edge where psum_valid is
// high, except while DRAIN, where it is discarded and flagged. There is no
// ready; the producer must not send beats while busy drains a tile.
module psum_accumulator
    import fsrcnn_pkg::*;
#(
    parameter int ADDR_W = PSUM_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_load,
    input  logic [TM*ACC_W-1:0]      bias_in,
    input  logic [TM*ALPHA_W-1:0]    alpha_in,
    input  logic [SHIFT_W-1:0]       frac_shift,
    input  logic                     psum_valid,
    input  logic [TM*ACC_W-1:0]      psum_in,
    input  logic [ADDR_W-1:0]        psum_addr,
    input  logic                     psum_first,
    input  logic                     psum_last,
    input  logic                     tile_end,
    output logic                     out_valid,
    output logic [TM*DATA_W-1:0]     out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     busy,
    output logic                     tile_done,
    output logic                     drop_err
);

    localparam int DEPTH = 1 << ADDR_W;

    // Control
    fsm_state_t state_q, state_d;
    logic       drain_cnt_q, drain_cnt_d;
    logic       tile_done_q, tile_done_d;
    logic       drop_err_q, drop_err_d;

    // Configuration
    logic [TM*ACC_W-1:0]   bias_q, bias_d;
    logic [TM*ALPHA_W-1:0] alpha_q, alpha_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;

    // Stage 1
    logic [TM*ACC_W-1:0] buf_mem [DEPTH];
    logic [TM*ACC_W-1:0] buf_rd;
    logic [TM*ACC_W-1:0] sum_vec;
    logic                beat_acc;
    logic                buf_we;
    logic [TM*ACC_W-1:0] s1_val_q, s1_val_d;
    logic                s1_vld_q, s1_vld_d;
    logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;

    // Stage 2
    logic [TM*DATA_W-1:0] q_vec;
    logic [TM*DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
    logic                 out_valid_q, out_valid_d;

    assign beat_acc = psum_valid && (state_q != DRAIN);
    assign buf_we   = beat_acc && !psum_last;
    assign buf_rd   = buf_mem[psum_addr];

    // ---------------- Control FSM ----------------
    // DRAIN spans two cycles: the first lets the final stage-1 result move
    // into stage 2 (and pulses tile_done alongside it), the second returns.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        tile_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (psum_valid) begin
                    state_d     = tile_end ? DRAIN : RUN;
                    drain_cnt_d = 1'b0;
                end
            end
            RUN: begin
                if (psum_valid && tile_end) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            DRAIN: begin
                if (!drain_cnt_q) begin
                    drain_cnt_d = 1'b1;
                    tile_done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Configuration / error flag ----------------
    always_comb begin
        bias_d  = bias_q;
        alpha_d = alpha_q;
        shift_d = shift_q;
        if (cfg_load && (state_q == IDLE)) begin
            bias_d  = bias_in;
            alpha_d = alpha_in;
            shift_d = frac_shift;
        end

        // A dropped beat takes priority over a same-cycle clear.
        drop_err_d = drop_err_q;
        if (psum_valid && (state_q == DRAIN)) begin
            drop_err_d = 1'b1;
        end else if (cfg_load) begin
            drop_err_d = 1'b0;
        end
    end

    // ---------------- Stage 1: accumulate ----------------
    always_comb begin
        sum_vec   = '0;
        s1_val_d  = s1_val_q;
        s1_addr_d = s1_addr_q;
        s1_vld_d  = beat_acc && psum_last;
        for (int k = 0; k < TM; k++) begin
            sum_vec[k*ACC_W +: ACC_W] = (psum_first ? '0 : buf_rd[k*ACC_W +: ACC_W])
                                        + psum_in[k*ACC_W +: ACC_W];
        end
        if (beat_acc && psum_last) begin
            s1_addr_d = psum_addr;
            for (int k = 0; k < TM; k++) begin
                s1_val_d[k*ACC_W +: ACC_W] = sum_vec[k*ACC_W +: ACC_W]
                                             + bias_q[k*ACC_W +: ACC_W];
            end
        end
    end

    // Buffer contents are defined by psum_first, so the array has no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[psum_addr] <= sum_vec;
        end
    end

    // ---------------- Stage 2: activate / quantise ----------------
    for (genvar g = 0; g < TM; g++) begin : g_act
        prelu_quant u_prelu_quant (
            .v_in  (s1_val_q[g*ACC_W +: ACC_W]),
            .alpha (alpha_q[g*ALPHA_W +: ALPHA_W]),
            .shift (shift_q),
            .q_out (q_vec[g*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        out_valid_d = s1_vld_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        if (s1_vld_q) begin
            out_data_d = q_vec;
            out_addr_d = s1_addr_q;
        end
    end

    // ---------------- State registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= 1'b0;
            tile_done_q <= 1'b0;
            drop_err_q  <= 1'b0;
            bias_q      <= '0;
            alpha_q     <= '0;
            shift_q     <= '0;
            s1_val_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_addr_q   <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            tile_done_q <= tile_done_d;
            drop_err_q  <= drop_err_d;
            bias_q      <= bias_d;
            alpha_q     <= alpha_d;
            shift_q     <= shift_d;
            s1_val_q    <= s1_val_d;
            s1_vld_q    <= s1_vld_d;
            s1_addr_q   <= s1_addr_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = (state_q != IDLE);
    assign tile_done = tile_done_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with hand-computed expected values.
module tb_psum_accumulator;
    import fsrcnn_pkg::*;

    localparam int AW = 6;

    logic                  clk;
    logic                  rst;
    logic                  cfg_load;
    logic [TM*ACC_W-1:0]   bias_in;
    logic [TM*ALPHA_W-1:0] alpha_in;
    logic [SHIFT_W-1:0]    frac_shift;
    logic                  psum_valid;
    logic [TM*ACC_W-1:0]   psum_in;
    logic [AW-1:0]         psum_addr;
    logic                  psum_first;
    logic                  psum_last;
    logic                  tile_end;
    logic                  out_valid;
    logic [TM*DATA_W-1:0]  out_data;
    logic [AW-1:0]         out_addr;
    logic                  busy;
    logic                  tile_done;
    logic                  drop_err;

    int n_tests = 0;
    int n_fail  = 0;

    psum_accumulator #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .bias_in    (bias_in),
        .alpha_in   (alpha_in),
        .frac_shift (frac_shift),
        .psum_valid (psum_valid),
        .psum_in    (psum_in),
        .psum_addr  (psum_addr),
        .psum_first (psum_first),
        .psum_last  (psum_last),
        .tile_end   (tile_end),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .busy       (busy),
        .tile_done  (tile_done),
        .drop_err   (drop_err)
    );

    // ---------------- Clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- Helpers ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TM*ACC_W-1:0] pk_acc(input int c0, input int c1, input int c2, input int c3);
        return {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
    endfunction

    function automatic logic [63:0] pk_out(input int c0, input int c1, input int c2, input int c3);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    // Driver tasks: inputs change on the falling edge; each call returns on
    // the falling edge that follows the rising edge which consumed it.
    task automatic do_cfg(input int bias, input int alpha, input int shift);
        bias_in    = {TM{32'(bias)}};
        alpha_in   = {TM{16'(alpha)}};
        frac_shift = 5'(shift);
        cfg_load   = 1'b1;
        @(negedge clk);
        cfg_load   = 1'b0;
    endtask

    task automatic send_beat(input logic [AW-1:0] addr, input logic first, input logic last,
                             input logic tend, input logic [TM*ACC_W-1:0] vals);
        psum_addr  = addr;
        psum_first = first;
        psum_last  = last;
        tile_end   = tend;
        psum_in    = vals;
        psum_valid = 1'b1;
        @(negedge clk);
        psum_valid = 1'b0;
        psum_first = 1'b0;
        psum_last  = 1'b0;
        tile_end   = 1'b0;
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        rst        = 1'b1;
        cfg_load   = 1'b0;
        bias_in    = '0;
        alpha_in   = '0;
        frac_shift = '0;
        psum_valid = 1'b0;
        psum_in    = '0;
        psum_addr  = '0;
        psum_first = 1'b0;
        psum_last  = 1'b0;
        tile_end   = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data",  64'(out_data),  64'd0);
        check_eq("rst_out_addr",  64'(out_addr),  64'd0);
        check_eq("rst_busy",      64'(busy),      64'd0);
        check_eq("rst_tile_done", 64'(tile_done), 64'd0);
        check_eq("rst_drop_err",  64'(drop_err),  64'd0);
        check_eq("rst_state",     64'(dut.state_q), 64'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Three passes on addr 3: (50+k) + 70 - 20 + bias 100 = 200+k.
        do_cfg(100, 16'h2000, 0);
        send_beat(6'd3, 1'b1, 1'b0, 1'b0, pk_acc(50, 51, 52, 53));
        check_eq("t1_busy_run", 64'(busy), 64'd1);
        send_beat(6'd3, 1'b0, 1'b0, 1'b0, pk_acc(70, 70, 70, 70));
        send_beat(6'd3, 1'b0, 1'b1, 1'b1, pk_acc(-20, -20, -20, -20));
        check_eq("t1_no_early_valid", 64'(out_valid), 64'd0);
        check_eq("t1_no_early_done",  64'(tile_done), 64'd0);
        @(negedge clk);
        check_eq("t1_out_valid", 64'(out_valid), 64'd1);
        check_eq("t1_out_data",  64'(out_data),  pk_out(200, 201, 202, 203));
        check_eq("t1_out_addr",  64'(out_addr),  64'd3);
        check_eq("t1_tile_done", 64'(tile_done), 64'd1);
        check_eq("t1_busy_drain", 64'(busy), 64'd1);
        @(negedge clk);
        check_eq("t1_valid_pulse", 64'(out_valid), 64'd0);
        check_eq("t1_done_pulse",  64'(tile_done), 64'd0);
        check_eq("t1_busy_idle",   64'(busy),      64'd0);

        // Negative PReLU with alpha 0.25, floor rounding: -401/4 -> -101, -1/4 -> -1.
        do_cfg(0, 16'h2000, 0);
        send_beat(6'd0, 1'b1, 1'b1, 1'b1, pk_acc(-400, -401, 400, -1));
        @(negedge clk);
        check_eq("t2_prelu_valid", 64'(out_valid), 64'd1);
        check_eq("t2_prelu_q",     64'(out_data), pk_out(-100, -101, 400, -1));
        @(negedge clk);
        do_cfg(0, 0, 0);
        send_beat(6'd0, 1'b1, 1'b1, 1'b1, pk_acc(-400, -401, 400, -1));
        @(negedge clk);
        check_eq("t2_alpha0", 64'(out_data), pk_out(0, 0, 400, 0));
        @(negedge clk);

        // Saturation after shift 4.
        do_cfg(0, 16'h2000, 4);
        send_beat(6'd1, 1'b1, 1'b1, 1'b1, pk_acc(32'h0010_0000, 32'h0007_FFF0, 32'h0008_0000, 16));
        @(negedge clk);
        check_eq("t3_sat_pos", 64'(out_data), pk_out(32767, 32767, 32767, 1));
        @(negedge clk);
        do_cfg(0, 16'h7FFF, 4);
        send_beat(6'd1, 1'b1, 1'b1, 1'b1, pk_acc(-1048576, -16, 0, -524288));
        @(negedge clk);
        check_eq("t3_sat_neg", 64'(out_data), pk_out(-32768, -1, 0, -32767));
        @(negedge clk);

        // Back-to-back beats to one address: 1+2+3.
        do_cfg(0, 16'h2000, 0);
        send_beat(6'd5, 1'b1, 1'b0, 1'b0, pk_acc(1, 1, 1, 1));
        send_beat(6'd5, 1'b0, 1'b0, 1'b0, pk_acc(2, 2, 2, 2));
        send_beat(6'd5, 1'b0, 1'b1, 1'b1, pk_acc(3, 3, 3, 3));
        @(negedge clk);
        check_eq("t4_b2b_data", 64'(out_data), pk_out(6, 6, 6, 6));
        check_eq("t4_b2b_addr", 64'(out_addr), 64'd5);
        @(negedge clk);

        // Interleaved addresses 5 and 6 accumulate independently.
        send_beat(6'd5, 1'b1, 1'b0, 1'b0, pk_acc(10, 10, 10, 10));
        send_beat(6'd6, 1'b1, 1'b0, 1'b0, pk_acc(100, 100, 100, 100));
        send_beat(6'd5, 1'b0, 1'b0, 1'b0, pk_acc(20, 20, 20, 20));
        send_beat(6'd6, 1'b0, 1'b0, 1'b0, pk_acc(200, 200, 200, 200));
        send_beat(6'd5, 1'b0, 1'b1, 1'b0, pk_acc(30, 30, 30, 30));
        send_beat(6'd6, 1'b0, 1'b1, 1'b1, pk_acc(300, 300, 300, 300));
        check_eq("t4_il5_valid", 64'(out_valid), 64'd1);
        check_eq("t4_il5_addr",  64'(out_addr),  64'd5);
        check_eq("t4_il5_data",  64'(out_data),  pk_out(60, 60, 60, 60));
        @(negedge clk);
        check_eq("t4_il6_addr",  64'(out_addr),  64'd6);
        check_eq("t4_il6_data",  64'(out_data),  pk_out(600, 600, 600, 600));
        check_eq("t4_il6_done",  64'(tile_done), 64'd1);
        @(negedge clk);

        // Beat during DRAIN is dropped and leaves the buffer untouched.
        send_beat(6'd7, 1'b1, 1'b0, 1'b1, pk_acc(40, 40, 40, 40));
        send_beat(6'd7, 1'b0, 1'b0, 1'b0, pk_acc(1000, 1000, 1000, 1000));
        check_eq("t5_drop_err", 64'(drop_err), 64'd1);
        @(negedge clk);
        check_eq("t5_drain_idle", 64'(busy), 64'd0);
        send_beat(6'd7, 1'b0, 1'b1, 1'b1, pk_acc(2, 2, 2, 2));
        @(negedge clk);
        check_eq("t5_buf_kept",    64'(out_data), pk_out(42, 42, 42, 42));
        check_eq("t5_drop_sticky", 64'(drop_err), 64'd1);
        @(negedge clk);
        do_cfg(0, 16'h2000, 0);
        check_eq("t5_drop_clear", 64'(drop_err), 64'd0);

        // cfg_load while RUN is ignored: old bias 0 applies (5+6=11).
        send_beat(6'd8, 1'b1, 1'b0, 1'b0, pk_acc(5, 5, 5, 5));
        do_cfg(500, 16'h2000, 0);
        send_beat(6'd8, 1'b0, 1'b1, 1'b1, pk_acc(6, 6, 6, 6));
        @(negedge clk);
        check_eq("t5_cfg_ignored", 64'(out_data), pk_out(11, 11, 11, 11));
        @(negedge clk);

        // Asynchronous reset with a result sitting in stage 1.
        send_beat(6'd9, 1'b1, 1'b1, 1'b1, pk_acc(77, 77, 77, 77));
        rst = 1'b1;
        #1;
        check_eq("t6_async_busy",  64'(busy),      64'd0);
        check_eq("t6_async_state", 64'(dut.state_q), 64'(IDLE));
        @(negedge clk);
        check_eq("t6_lost_valid", 64'(out_valid), 64'd0);
        check_eq("t6_no_done",    64'(tile_done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_after_valid", 64'(out_valid), 64'd0);
        // Config is back to zero: bias 0, alpha 0, shift 0.
        send_beat(6'd9, 1'b1, 1'b1, 1'b1, pk_acc(77, -8, 0, 3));
        @(negedge clk);
        check_eq("t6_recover_valid", 64'(out_valid), 64'd1);
        check_eq("t6_recover_data",  64'(out_data),  pk_out(77, 0, 0, 3));
        check_eq("t6_recover_addr",  64'(out_addr),  64'd9);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
